dls_fault_ctrl: RTL

DLS_FAULT_CTRL -- requirements
Module: dls_fault_ctrl

---
 rtl/dls_fault_ctrl.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/dls_fault_ctrl.sv
// -----------------------------------------------------------------------------
// dls_fault_ctrl
//
// Fault supervisor for a dual-lockstep VGA pair. It filters the lockstep
// comparator mismatch flag, counts short glitches, and on a confirmed fault
// pulses a soft reset to both VGA instances and then waits for a VSYNC rising
// edge before declaring the pair healthy again. After too many confirmed faults
// it locks out until software unlocks it. An AHB-Lite slave exposes a
// read-only STATUS word and a write-only CTRL word.
//
// Ports
//   HCLK, HRESETn      clock, asynchronous active-low reset
//   DLS_ERROR          lockstep comparator mismatch flag
//   VSYNC              primary VGA vertical sync (HCLK domain)
//   HSEL/HREADY/HWRITE/HTRANS/HADDR/HWDATA   AHB-Lite slave inputs
//   HRDATA, HREADYOUT  AHB-Lite slave outputs (zero wait states)
//   VGA_SRST_n         active-low soft reset to both VGA instances
//   FAULT_IRQ          sticky fault interrupt
//   FATAL              high while locked out
//
// Register map (HADDR[3:2])
//   0x0 STATUS  [2:0] state, [3] FATAL, [4] FAULT_IRQ,
//               [15:8] glitch_cnt, [23:16] retry_cnt
//   0x4 CTRL    bit0 clear IRQ, bit1 clear counters, bit2 unlock (reads 0)
//   0x8/0xC     reserved, read 0
//
// state    | meaning
// ---------+-------------------------------------------------------------
// OK       | pair healthy, watching DLS_ERROR
// SUSPECT  | mismatch seen, counting consecutive error cycles
// RECOVER  | soft reset held low for RST_CYC cycles
// RESYNC   | waiting for a VSYNC rising edge before returning to OK
// LOCKOUT  | retry budget exhausted, FATAL high until reset or unlock
// -----------------------------------------------------------------------------
module dls_fault_ctrl #(
    parameter int unsigned FILTER_CYC = 4,
    parameter int unsigned RST_CYC    = 16,
    parameter int unsigned MAX_RETRY  = 3
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        DLS_ERROR,
    input  logic        VSYNC,
    input  logic        HSEL,
    input  logic        HREADY,
    input  logic        HWRITE,
    input  logic [1:0]  HTRANS,
    input  logic [31:0] HADDR,
    input  logic [31:0] HWDATA,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        VGA_SRST_n,
    output logic        FAULT_IRQ,
    output logic        FATAL
);

    typedef enum logic [2:0] {
        ST_OK      = 3'd0,
        ST_SUSPECT = 3'd1,
        ST_RECOVER = 3'd2,
        ST_RESYNC  = 3'd3,
        ST_LOCKOUT = 3'd4
    } state_t;

    localparam logic [7:0] FILTER_C = 8'(FILTER_CYC);
    localparam logic [7:0] RST_C    = 8'(RST_CYC);
    localparam logic [7:0] MAX_C    = 8'(MAX_RETRY);

    localparam logic [1:0] A_STATUS = 2'd0;
    localparam logic [1:0] A_CTRL   = 2'd1;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    state_t      state_q, state_d;
    logic [7:0]  err_cnt_q, err_cnt_d;
    logic [7:0]  glitch_cnt_q, glitch_cnt_d;
    logic [7:0]  retry_cnt_q, retry_cnt_d;
    logic [7:0]  tmr_q, tmr_d;
    logic        irq_q, irq_d;
    logic        fatal_q, fatal_d;
    logic        srst_n_q, srst_n_d;
    logic        vsync_q, vsync_d;

    logic        dph_valid_q, dph_valid_d;
    logic        dph_write_q, dph_write_d;
    logic [1:0]  dph_addr_q, dph_addr_d;

    logic        confirm;
    logic [7:0]  retry_inc;
    logic        ctrl_wr;
    logic        status_rd;
    logic [31:0] status;
    logic        unused_bits;

    assign unused_bits = ^{HADDR[31:4], HADDR[1:0], HWDATA[31:3]};

    // Address phase captured here; the CTRL write uses HWDATA one cycle later.
    always_comb begin
        dph_valid_d = HSEL & HREADY & HTRANS[1];
        dph_write_d = HWRITE;
        dph_addr_d  = HADDR[3:2];
    end

    assign ctrl_wr   = dph_valid_q & dph_write_q & (dph_addr_q == A_CTRL);
    assign status_rd = dph_valid_q & ~dph_write_q & (dph_addr_q == A_STATUS);
    assign retry_inc = sat_inc(retry_cnt_q);

    always_comb begin
        state_d      = state_q;
        err_cnt_d    = err_cnt_q;
        glitch_cnt_d = glitch_cnt_q;
        retry_cnt_d  = retry_cnt_q;
        tmr_d        = tmr_q;
        irq_d        = irq_q;
        vsync_d      = VSYNC;
        confirm      = 1'b0;

        case (state_q)
            ST_OK: begin
                if (DLS_ERROR) begin
                    if (FILTER_C == 8'd1) begin
                        confirm = 1'b1;
                    end else begin
                        state_d   = ST_SUSPECT;
                        err_cnt_d = 8'd1;
                    end
                end
            end
            ST_SUSPECT: begin
                if (DLS_ERROR) begin
                    if (err_cnt_q + 8'd1 == FILTER_C) begin
                        confirm = 1'b1;
                    end else begin
                        err_cnt_d = err_cnt_q + 8'd1;
                    end
                end else begin
                    state_d      = ST_OK;
                    err_cnt_d    = 8'd0;
                    glitch_cnt_d = sat_inc(glitch_cnt_q);
                end
            end
            ST_RECOVER: begin
                if (tmr_q == 8'd0) begin
                    state_d = ST_RESYNC;
                end else begin
                    tmr_d = tmr_q - 8'd1;
                end
            end
            ST_RESYNC: begin
                if (VSYNC && !vsync_q) begin
                    state_d = ST_OK;
                end
            end
            ST_LOCKOUT: begin
                if (ctrl_wr && HWDATA[2]) begin
                    state_d     = ST_OK;
                    retry_cnt_d = 8'd0;
                end
            end
            default: begin
                state_d = ST_OK;
            end
        endcase

        // IRQ clear is applied before the fault set so a coincident fault wins.
        if (ctrl_wr && HWDATA[0]) begin
            irq_d = 1'b0;
        end

        if (confirm) begin
            err_cnt_d   = 8'd0;
            retry_cnt_d = retry_inc;
            irq_d       = 1'b1;
            tmr_d       = RST_C - 8'd1;
            state_d     = (retry_inc > MAX_C) ? ST_LOCKOUT : ST_RECOVER;
        end

        // Counter clear overrides any increment in the same cycle.
        if (ctrl_wr && HWDATA[1]) begin
            glitch_cnt_d = 8'd0;
            retry_cnt_d  = 8'd0;
        end

        // Outputs are registered from the next state so they line up with it.
        srst_n_d = (state_d != ST_RECOVER);
        fatal_d  = (state_d == ST_LOCKOUT);
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q      <= ST_OK;
            err_cnt_q    <= 8'd0;
            glitch_cnt_q <= 8'd0;
            retry_cnt_q  <= 8'd0;
            tmr_q        <= 8'd0;
            irq_q        <= 1'b0;
            fatal_q      <= 1'b0;
            srst_n_q     <= 1'b1;
            vsync_q      <= 1'b0;
            dph_valid_q  <= 1'b0;
            dph_write_q  <= 1'b0;
            dph_addr_q   <= 2'd0;
        end else begin
            state_q      <= state_d;
            err_cnt_q    <= err_cnt_d;
            glitch_cnt_q <= glitch_cnt_d;
            retry_cnt_q  <= retry_cnt_d;
            tmr_q        <= tmr_d;
            irq_q        <= irq_d;
            fatal_q      <= fatal_d;
            srst_n_q     <= srst_n_d;
            vsync_q      <= vsync_d;
            dph_valid_q  <= dph_valid_d;
            dph_write_q  <= dph_write_d;
            dph_addr_q   <= dph_addr_d;
        end
    end

    assign status = {8'h00, retry_cnt_q, glitch_cnt_q, 3'b000, irq_q, fatal_q, state_q};

    // Read data reflects live register state during the data phase.
    always_comb begin
        HRDATA = 32'h0;
        if (status_rd) begin
            HRDATA = status;
        end
    end

    assign HREADYOUT  = 1'b1;
    assign VGA_SRST_n = srst_n_q;
    assign FAULT_IRQ  = irq_q;
    assign FATAL      = fatal_q;

endmodule
